// File: rtl/loopback_arbiter.sv
// Round-robin scheduler that moves a programmed number of words from the stream FIFO and the
// buffer-read FIFO into the output buffer. Optional running checksum: LOOPBACK_ARB_CKSUM_EN.
module loopback_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_stream_count,
    input  logic [CNT_W-1:0]  cfg_buffer_count,
    output logic              busy,
    output logic              done,
    input  logic              stream_fifo_empty,
    input  logic [DATA_W-1:0] stream_fifo_data_out,
    output logic              stream_fifo_pop,
    input  logic              buffer_read_empty,
    input  logic [DATA_W-1:0] buffer_read_data_out,
    output logic              buffer_read_pop,
    input  logic              outbuf_full,
    output logic              outbuf_push,
    output logic [DATA_W-1:0] outbuf_data_in,
`ifdef LOOPBACK_ARB_CKSUM_EN
    output logic              outbuf_src,
    output logic [31:0]       cksum
`else
    output logic              outbuf_src
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_s_q, rem_s_d;
    logic [CNT_W-1:0]  rem_b_q, rem_b_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              last_grant_q, last_grant_d;

    logic elig_s, elig_b, slot_free, push, grant_s, grant_b;

    always_comb begin
        state_d      = state_q;
        rem_s_d      = rem_s_q;
        rem_b_d      = rem_b_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        grant_s      = 1'b0;
        grant_b      = 1'b0;

        elig_s    = (rem_s_q != '0) && !stream_fifo_empty;
        elig_b    = (rem_b_q != '0) && !buffer_read_empty;
        push      = out_valid_q && !outbuf_full;
        slot_free = !out_valid_q || push;

        if (state_q == StRun && slot_free) begin
            if (elig_s && elig_b) begin
                // Tie goes to whichever source was not served last (1 = buffer).
                if (last_grant_q) begin
                    grant_s = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (elig_s) begin
                grant_s = 1'b1;
            end else if (elig_b) begin
                grant_b = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_s_d = cfg_stream_count;
                    rem_b_d = cfg_buffer_count;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Finish as soon as the last word leaves the output register.
                if (rem_s_q == '0 && rem_b_q == '0 && slot_free) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (push) begin
            out_valid_d = 1'b0;
        end
        if (grant_s) begin
            out_valid_d  = 1'b1;
            out_data_d   = stream_fifo_data_out;
            out_src_d    = 1'b0;
            rem_s_d      = rem_s_q - CNT_W'(1);
            last_grant_d = 1'b0;
        end else if (grant_b) begin
            out_valid_d  = 1'b1;
            out_data_d   = buffer_read_data_out;
            out_src_d    = 1'b1;
            rem_b_d      = rem_b_q - CNT_W'(1);
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rem_s_q      <= '0;
            rem_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rem_s_q      <= rem_s_d;
            rem_b_q      <= rem_b_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        busy            = (state_q == StRun);
        done            = (state_q == StDone);
        stream_fifo_pop = grant_s;
        buffer_read_pop = grant_b;
        outbuf_push     = push;
        outbuf_data_in  = out_data_q;
        outbuf_src      = out_src_q;
    end

`ifdef LOOPBACK_ARB_CKSUM_EN
    localparam int unsigned NCHUNK = (DATA_W + 31) / 32;

    logic [NCHUNK*32-1:0] pad;
    logic [31:0]          chunk_sum;
    logic [31:0]          cksum_q, cksum_d;

    always_comb begin
        pad                = '0;
        pad[DATA_W-1:0]    = out_data_q;
        chunk_sum          = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            chunk_sum = chunk_sum + pad[i*32 +: 32];
        end
        cksum_d = cksum_q;
        if (state_q == StIdle && start) begin
            cksum_d = '0;
        end else if (push) begin
            cksum_d = cksum_q + chunk_sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_loopback_arbiter.sv
// Directed and randomized bench for loopback_arbiter; sources are modelled as queues and every
// pushed word is scored against the order in which words were popped.
module tb_loopback_arbiter;

    localparam int DW = 64;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_s = '0, cfg_b = '0;
    logic          busy, done;
    logic          stream_fifo_empty, buffer_read_empty, outbuf_full;
    logic [DW-1:0] stream_fifo_data_out, buffer_read_data_out;
    logic          stream_fifo_pop, buffer_read_pop, outbuf_push, outbuf_src;
    logic [DW-1:0] outbuf_data_in;
`ifdef LOOPBACK_ARB_CKSUM_EN
    logic [31:0]   cksum, obs_cksum, model_sum;
`endif

    loopback_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
`ifdef LOOPBACK_ARB_CKSUM_EN
        .cksum                (cksum),
`endif
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .cfg_stream_count     (cfg_s),
        .cfg_buffer_count     (cfg_b),
        .busy                 (busy),
        .done                 (done),
        .stream_fifo_empty    (stream_fifo_empty),
        .stream_fifo_data_out (stream_fifo_data_out),
        .stream_fifo_pop      (stream_fifo_pop),
        .buffer_read_empty    (buffer_read_empty),
        .buffer_read_data_out (buffer_read_data_out),
        .buffer_read_pop      (buffer_read_pop),
        .outbuf_full          (outbuf_full),
        .outbuf_push          (outbuf_push),
        .outbuf_data_in       (outbuf_data_in),
        .outbuf_src           (outbuf_src)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, viol = 0;
    int ps, pb, np, done_cnt, done_cyc, start_cyc;
    int first_pop_cyc, last_pop_cyc, first_push_cyc, last_push_cyc;
    logic [64:0] exp_out[$], push_log[$], exp_job[$];
    logic [63:0] sq[$], bq[$], sw[$], bw[$];
    bit rand_mode = 0, full_force = 0, model_last = 1;
    bit do_pop_s, do_pop_b;
    logic obs_push, obs_pop, obs_busy;
    logic [63:0] obs_data;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        stream_fifo_empty    = (sq.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
        stream_fifo_data_out = (sq.size() != 0) ? sq[0] : '0;
        buffer_read_empty    = (bq.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
        buffer_read_data_out = (bq.size() != 0) ? bq[0] : '0;
        outbuf_full          = full_force || (rand_mode && $urandom_range(0, 2) == 0);
    endtask

    // Observe one cycle at the falling edge, then retire pops and re-drive sources.
    task automatic step();
        @(negedge clk);
        cyc++;
        obs_push = outbuf_push;
        obs_pop  = stream_fifo_pop | buffer_read_pop;
        obs_data = outbuf_data_in;
        obs_busy = busy;
        if (outbuf_push) begin
            if (exp_out.size() == 0) begin
                viol++;
            end else begin
                check("push_word", {7'd0, outbuf_src, outbuf_data_in}, {7'd0, exp_out[0]});
                void'(exp_out.pop_front());
            end
            push_log.push_back({outbuf_src, outbuf_data_in});
            np++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
            last_push_cyc = cyc;
`ifdef LOOPBACK_ARB_CKSUM_EN
            model_sum = model_sum + outbuf_data_in[31:0] + outbuf_data_in[63:32];
`endif
        end
        do_pop_s = stream_fifo_pop;
        do_pop_b = buffer_read_pop;
        if (do_pop_s && do_pop_b) viol++;
        if (do_pop_s) begin
            if (stream_fifo_empty || sq.size() == 0) viol++;
            else exp_out.push_back({1'b0, sq[0]});
            ps++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (do_pop_b) begin
            if (buffer_read_empty || bq.size() == 0) viol++;
            else exp_out.push_back({1'b1, bq[0]});
            pb++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef LOOPBACK_ARB_CKSUM_EN
            obs_cksum = cksum;
`endif
        end
        @(posedge clk);
        #1;
        if (do_pop_s && sq.size() != 0) void'(sq.pop_front());
        if (do_pop_b && bq.size() != 0) void'(bq.pop_front());
        drive();
    endtask

    task automatic fill(input int ns, input int nb, input logic [63:0] sbase, input logic [63:0] bbase);
        sq.delete();
        bq.delete();
        for (int i = 0; i < ns; i++) sq.push_back(sbase + 64'(i));
        for (int i = 0; i < nb; i++) bq.push_back(bbase + 64'(i));
        drive();
    endtask

    task automatic start_job(input int cs, input int cb);
        exp_out.delete();
        push_log.delete();
        ps = 0; pb = 0; np = 0; viol = 0; done_cnt = 0; done_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; first_push_cyc = -1; last_push_cyc = -1;
`ifdef LOOPBACK_ARB_CKSUM_EN
        model_sum = '0;
`endif
        sw = sq;
        bw = bq;
        cfg_s = CW'(cs);
        cfg_b = CW'(cb);
        start = 1'b1;
        step();
        start_cyc = cyc;
        start = 1'b0;
        cfg_s = CW'($urandom);
        cfg_b = CW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            step();
            n++;
        end
        check({tag, "_busy_in_done"}, 72'(obs_busy), 72'd0);
        step();
        check({tag, "_one_done"}, 72'(done_cnt), 72'd1);
        check({tag, "_idle_after"}, 72'(obs_busy), 72'd0);
    endtask

    // Expected output order when every source always has data: plain round-robin on counts.
    task automatic model_order(input int cs, input int cb);
        int si = 0, bi = 0;
        bit pick_b;
        exp_job.delete();
        while (cs > 0 || cb > 0) begin
            pick_b = (cs == 0) || (cb > 0 && model_last == 1'b0);
            if (pick_b) begin
                exp_job.push_back({1'b1, bw[bi]});
                bi++; cb--;
            end else begin
                exp_job.push_back({1'b0, sw[si]});
                si++; cs--;
            end
            model_last = pick_b;
        end
    endtask

    task automatic check_job(input string tag, input int cs, input int cb);
        check({tag, "_stream_pops"}, 72'(ps), 72'(cs));
        check({tag, "_buffer_pops"}, 72'(pb), 72'(cb));
        check({tag, "_pushes"}, 72'(np), 72'(cs + cb));
        check({tag, "_protocol"}, 72'(viol), 72'd0);
        if (!rand_mode) begin
            for (int i = 0; i < exp_job.size() && i < push_log.size(); i++) begin
                check({tag, "_order"}, {7'd0, push_log[i]}, {7'd0, exp_job[i]});
            end
        end
    endtask

    initial begin
        drive();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Abort a 5/5 job with reset while words are in flight.
        fill(6, 6, 64'hA0, 64'hB0);
        start_job(5, 5);
        step();
        check("run_busy", 72'(obs_busy), 72'd1);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, stream_fifo_pop, buffer_read_pop, outbuf_push,
                                outbuf_src, 2'b0, outbuf_data_in}, 72'd0);
`ifdef LOOPBACK_ARB_CKSUM_EN
        check("reset_cksum", 72'(cksum), 72'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_last = 1'b1;

        // Zero-length job: done two cycles after start, nothing moved.
        fill(2, 2, 64'hE0, 64'hF0);
        start_job(0, 0);
        wait_done("zero");
        check("zero_done_lat", 72'(done_cyc - start_cyc), 72'd2);
        check("zero_traffic", 72'(ps + pb + np), 72'd0);

        fill(3, 3, 64'h31, 64'h41);
        start_job(3, 3);
        model_order(3, 3);
        wait_done("rr");
        check_job("rr", 3, 3);

        // Uneven counts, with an ignored start mid-job.
        fill(2, 4, 64'h51, 64'h61);
        start_job(1, 3);
        model_order(1, 3);
        step();
        cfg_s = CW'(7);
        cfg_b = CW'(7);
        start = 1'b1;
        step();
        start = 1'b0;
        check("uneven_busy_kept", 72'(obs_busy), 72'd1);
        wait_done("uneven");
        check_job("uneven", 1, 3);

        fill(4, 2, 64'h11, 64'h71);
        start_job(4, 0);
        model_order(4, 0);
        wait_done("sonly");
        check_job("sonly", 4, 0);
        check("sonly_first_pop", 72'(first_pop_cyc - start_cyc), 72'd1);
        check("sonly_last_pop", 72'(last_pop_cyc - start_cyc), 72'd4);
        check("sonly_done_after_push", 72'(done_cyc - last_push_cyc), 72'd1);

        // Backpressure right after the first capture.
        fill(2, 0, 64'hC1, 64'h0);
        start_job(2, 0);
        model_order(2, 0);
        step();
        full_force = 1'b1;
        outbuf_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold", {6'd0, obs_pop, obs_push, obs_data}, {6'd0, 1'b0, 1'b0, 64'hC1});
        end
        full_force = 1'b0;
        outbuf_full = 1'b0;
        wait_done("bp");
        check_job("bp", 2, 0);
        check("bp_first_push", 72'(first_push_cyc - start_cyc), 72'd7);
        check("bp_back_to_back", 72'(last_push_cyc - first_push_cyc), 72'd1);

`ifdef LOOPBACK_ARB_CKSUM_EN
        sq.delete();
        bq.delete();
        sq.push_back(64'h00000001_00000002);
        sq.push_back(64'hFFFFFFFF_00000000);
        drive();
        start_job(2, 0);
        wait_done("ck");
        check("ck_value", 72'(obs_cksum), 72'h2);
`endif

        // Random counts, random source stalls and random output backpressure.
        rand_mode = 1;
        for (int j = 0; j < 25; j++) begin
            int cs, cb;
            cs = int'($urandom_range(0, 8));
            cb = int'($urandom_range(0, 8));
            sq.delete();
            bq.delete();
            for (int i = 0; i < cs + int'($urandom_range(0, 2)); i++) sq.push_back({$urandom, $urandom});
            for (int i = 0; i < cb + int'($urandom_range(0, 2)); i++) bq.push_back({$urandom, $urandom});
            drive();
            start_job(cs, cb);
            wait_done("rnd");
            check_job("rnd", cs, cb);
            check("rnd_drained", 72'(exp_out.size()), 72'd0);
`ifdef LOOPBACK_ARB_CKSUM_EN
            check("rnd_cksum", 72'(obs_cksum), 72'(model_sum));
`endif
        end
        rand_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
